// File: rtl/rca_word_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_word_seq : sequences a WIDTH-bit add over one external 4-bit RCA slice
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module rca_word_seq #(
  parameter int NWORDS = 4,
  parameter int WIDTH  = 4 * NWORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic [3:0]       add_carry
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operands and sum held as nibble arrays so the active slice is a plain index.
  logic [NWORDS-1:0][3:0] r_a;
  logic [NWORDS-1:0][3:0] r_b;
  logic [NWORDS-1:0][3:0] r_sum;
  logic                   r_cy;
  logic [IDXW-1:0]        r_idx;
  logic                   r_cout;
  logic                   r_ovf;

  logic w_accept;
  logic w_last;
  logic w_release;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_idx == C_LAST);
  assign w_release = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = r_a[r_idx];
        add_b   = r_b[r_idx];
        add_cin = r_cy;
        if (r_idx == C_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cy   <= 1'b0;
      r_idx  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_cy  <= in_cin;
        r_idx <= '0;
      end
      if (r_state == S_RUN) begin
        r_sum[r_idx] <= add_sum;
        r_cy         <= add_carry[3];
        if (w_last) begin
          r_idx  <= '0;
          // Signed overflow: carry into the MSB disagrees with carry out of it.
          r_cout <= add_carry[3];
          r_ovf  <= add_carry[3] ^ add_carry[2];
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Nothing in the datapath depends on the release edge; results persist.
  logic w_unused;
  assign w_unused = w_release;

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_word_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rca_word_seq : directed bench with a 4-bit RCA model on the add_* ports
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rca_word_seq;

  localparam int NWORDS = 4;
  localparam int WIDTH  = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic [3:0]       add_carry;

  int n_cmp;
  int n_err;

  rca_word_seq #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry)
  );

  // Bit-level ripple-carry slice standing in for the external adder.
  always_comb begin
    logic c;
    c         = add_cin;
    add_sum   = 4'd0;
    add_carry = 4'd0;
    for (int i = 0; i < 4; i++) begin
      add_sum[i]   = add_a[i] ^ add_b[i] ^ c;
      c            = (add_a[i] & add_b[i]) | (add_a[i] & c) | (add_b[i] & c);
      add_carry[i] = c;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency and result, then complete the handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic eo);
    int n;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_slice0_a"}, 32'(add_a), 32'(a[3:0]));
    check({tag, "_slice0_b"}, 32'(add_b), 32'(b[3:0]));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(out_sum), 32'(es));
    check({tag, "_cout"}, 32'(out_cout), 32'(ec));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    @(posedge clk);
    #1;
    check({tag, "_back_idle"}, 32'({in_ready, out_valid, busy}), 32'b100);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'hAAAA;
    in_b      = 16'h5555;
    in_cin    = 1'b1;
    out_ready = 1'b1;

    // Reset state, with a handshake attempt that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    run_op("t2", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    run_op("t3", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t4a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t4b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("t4c", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result held while out_ready low, new operands refused.
    @(negedge clk);
    out_ready = 1'b0;
    in_a      = 16'h00FF;
    in_b      = 16'h0F01;
    in_cin    = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_valid_up", 32'(out_valid), 32'd1);
    check("t5_sum", 32'(out_sum), 32'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_ready", 32'(in_ready), 32'd0);
      check("t5_hold_sum", 32'(out_sum), 32'h1000);
      check("t5_hold_add_a", 32'(add_a), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_released", 32'({in_ready, out_valid, busy}), 32'b100);
    check("t5_sum_persists", 32'(out_sum), 32'h1000);

    // Abort mid-RUN with an asynchronous reset pulse.
    @(negedge clk);
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_abort_state", 32'({in_ready, out_valid, busy}), 32'b100);
    check("t6_abort_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_valid", 32'(out_valid), 32'd0);
    run_op("t6", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
